// File: rtl/multiplier_pkg.sv
// multiplier_pkg: shared widths, arbiter state encoding and watchdog default
package multiplier_pkg;
  localparam int DATA_LENGTH = 64;
  localparam int MONT_TIMEOUT_DEFAULT = 2048;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
endpackage

// File: rtl/rr_grant.sv
// rr_grant: combinational round-robin arbiter, priority starts at ptr_i and wraps
module rr_grant #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);
  int best;
  // smallest cyclic distance from the pointer wins; best==N means no request
  always_comb begin
    best = N;
    idx_o = '0;
    gnt_o = '0;
    for (int i = 0; i < N; i++)
      if (req_i[i] && (i + N - int'(ptr_i)) % N < best) begin
        best = (i + N - int'(ptr_i)) % N;
        idx_o = IW'(i);
      end
    for (int i = 0; i < N; i++) gnt_o[i] = best < N && idx_o == IW'(i);
  end
endmodule

// File: rtl/mont_red_arbiter.sv
// mont_red_arbiter: round-robin sharing of one Montgomery reducer with a watchdog
module mont_red_arbiter
  import multiplier_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W = $clog2(NUM_REQ),
  parameter int TIMEOUT = MONT_TIMEOUT_DEFAULT
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           cfg_we_i,
  output logic                           cfg_ready_o,
  input  logic [DATA_LENGTH-1:0]         cfg_m_i,
  input  logic [DATA_LENGTH-1:0]         cfg_m_bl_i,
  input  logic [DATA_LENGTH-1:0]         cfg_minv_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*DATA_LENGTH-1:0] req_x_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [ID_W-1:0]                rsp_id_o,
  output logic [DATA_LENGTH-1:0]         rsp_data_o,
  output logic                           rsp_err_o,
  output logic                           red_start_o,
  output logic [DATA_LENGTH-1:0]         red_x_o,
  output logic [DATA_LENGTH-1:0]         red_m_o,
  output logic [DATA_LENGTH-1:0]         red_m_bl_o,
  output logic [DATA_LENGTH-1:0]         red_minv_o,
  input  logic                           red_valid_i,
  input  logic [DATA_LENGTH-1:0]         red_result_i,
  output logic [15:0]                    timeout_cnt_o
);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  arb_state_t state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d, id_q, id_d, g_idx;
  logic [NUM_REQ-1:0] g_oh;
  logic [DATA_LENGTH-1:0] m_q, m_d, bl_q, bl_d, minv_q, minv_d, x_q, x_d, data_q, data_d, x_sel;
  logic err_q, err_d, idle;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [15:0] tcnt_q, tcnt_d;
  rr_grant #(.N(NUM_REQ), .IW(ID_W)) u_rr (
    .req_i(req_valid_i),
    .ptr_i(ptr_q),
    .gnt_o(g_oh),
    .idx_o(g_idx)
  );
  // outputs stay low while reset is asserted, even though the state is IDLE
  assign idle = state_q == IDLE && rst_ni;
  assign cfg_ready_o = idle;
  assign req_ready_o = idle ? g_oh : '0;
  assign red_start_o = state_q == ISSUE;
  assign rsp_valid_o = state_q == RESP;
  assign rsp_id_o = id_q;
  assign rsp_data_o = data_q;
  assign rsp_err_o = err_q;
  assign red_x_o = x_q;
  assign red_m_o = m_q;
  assign red_m_bl_o = bl_q;
  assign red_minv_o = minv_q;
  assign timeout_cnt_o = tcnt_q;
  // operand of the granted requester
  always_comb begin
    x_sel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (g_oh[i]) x_sel = req_x_i[i*DATA_LENGTH +: DATA_LENGTH];
  end
  // next state: grant, issue, wait with watchdog, hold response
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    m_d = m_q;
    bl_d = bl_q;
    minv_d = minv_q;
    x_d = x_q;
    data_d = data_q;
    err_d = err_q;
    wd_d = wd_q;
    tcnt_d = tcnt_q;
    case (state_q)
      IDLE: begin
        if (cfg_we_i) begin
          m_d = cfg_m_i;
          bl_d = cfg_m_bl_i;
          minv_d = cfg_minv_i;
        end
        if (|req_valid_i) begin
          x_d = x_sel;
          id_d = g_idx;
          ptr_d = ID_W'((int'(g_idx) + 1) % NUM_REQ);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wd_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (red_valid_i) begin
          data_d = red_result_i;
          err_d = 1'b0;
          state_d = RESP;
        end else if (wd_q == WD_W'(TIMEOUT - 2)) begin
          data_d = '0;
          err_d = 1'b1;
          tcnt_d = tcnt_q + {15'd0, tcnt_q != 16'hFFFF};
          state_d = RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      RESP: state_d = rsp_ready_i ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, async active-low reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q <= '0;
      id_q <= '0;
      m_q <= '0;
      bl_q <= '0;
      minv_q <= '0;
      x_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
      wd_q <= '0;
      tcnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      m_q <= m_d;
      bl_q <= bl_d;
      minv_q <= minv_d;
      x_q <= x_d;
      data_q <= data_d;
      err_q <= err_d;
      wd_q <= wd_d;
      tcnt_q <= tcnt_d;
    end
  end
endmodule

// File: tb/tb_mont_red_arbiter.sv
// tb_mont_red_arbiter: scoreboard bench with a stub reducer
module tb_mont_red_arbiter;
  localparam int N = 4;
  localparam int TO = 16;
  typedef struct {
    logic [1:0]  id;
    logic [63:0] data;
    logic        err;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_we = 1'b0, cfg_ready;
  logic [63:0] cfg_m = '0, cfg_bl = '0, cfg_minv = '0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [63:0] xs [N];
  logic [N*64-1:0] req_x;
  logic rsp_valid, rsp_rdy = 1'b1, rsp_err, red_start, red_valid, spur = 1'b0;
  logic [1:0] rsp_id;
  logic [63:0] rsp_data, red_x, red_m, red_bl, red_minv, red_result;
  logic [15:0] tcnt;
  logic [2:0] scnt;
  int mode = 0;
  logic [63:0] mont_exp = '0, exp_m = '0, exp_bl = '0, exp_minv = '0;
  exp_t sb[$];
  int exp_gnt[$];
  int total = 0, bad = 0;
  int cyc = 0, ngnt = 0, starts = 0, gnt_cyc = 0, iss_cyc = 0, hs_cyc = 0;
  int lat_ref = 0, lat_exp = 0, gap_chk = 0;
  logic prev_start = 1'b0, prev_rv = 1'b0;

  always #5 clk = ~clk;
  assign req_x = {xs[3], xs[2], xs[1], xs[0]};

  mont_red_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_we_i(cfg_we), .cfg_ready_o(cfg_ready),
    .cfg_m_i(cfg_m), .cfg_m_bl_i(cfg_bl), .cfg_minv_i(cfg_minv),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_x_i(req_x),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_rdy), .rsp_id_o(rsp_id),
    .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .red_start_o(red_start), .red_x_o(red_x), .red_m_o(red_m),
    .red_m_bl_o(red_bl), .red_minv_o(red_minv),
    .red_valid_i(red_valid), .red_result_i(red_result),
    .timeout_cnt_o(tcnt)
  );

  function automatic logic [63:0] redc(logic [63:0] x, logic [63:0] m, logic [63:0] bl);
    logic [64:0] t = {1'b0, x};
    for (int i = 0; i < int'(bl[7:0]); i++) begin
      if (t[0]) t = t + {1'b0, m};
      t = t >> 1;
    end
    if (t >= {1'b0, m}) t = t - {1'b0, m};
    return t[63:0];
  endfunction

  // stub reducer: valid 5 cycles after the start cycle; mode 1 never answers
  always @(posedge clk or negedge rst_n)
    if (!rst_n) scnt <= '0;
    else if (red_start) scnt <= 3'd5;
    else if (scnt != 0) scnt <= scnt - 1'b1;
  assign red_valid = (scnt == 3'd1 && mode != 1) || spur;
  assign red_result = mode == 2 ? redc(red_x, red_m, red_bl) : red_x + 64'd1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // monitor: grant order, scoreboard push at grant, compare while response is held
  always @(negedge clk) if (rst_n) begin
    if (req_ready != '0) begin
      int g;
      exp_t e;
      g = 0;
      for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
      chk("gnt_onehot", 64'($onehot(req_ready)), 1);
      chk("gnt_has_valid", 64'(req_valid[g]), 1);
      chk("gnt_expected", 64'(exp_gnt.size() > 0), 1);
      if (exp_gnt.size() > 0) chk("gnt_order", 64'(g), 64'(exp_gnt.pop_front()));
      e.id = 2'(g);
      e.data = mode == 1 ? 64'd0 : mode == 2 ? mont_exp : xs[g] + 64'd1;
      e.err = mode == 1;
      sb.push_back(e);
      ngnt++;
      gnt_cyc = cyc;
      if (gap_chk != 0) begin
        chk("gnt_gap", 64'(cyc - hs_cyc), 1);
        gap_chk = 0;
      end
    end
    if (red_start) begin
      starts++;
      iss_cyc = cyc;
      chk("start_pulse", 64'(prev_start), 0);
      chk("red_m", red_m, exp_m);
      chk("red_bl", red_bl, exp_bl);
      chk("red_minv", red_minv, exp_minv);
    end
    prev_start = red_start;
    if (rsp_valid) begin
      chk("rsp_expected", 64'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        chk("rsp_id", 64'(rsp_id), 64'(sb[0].id));
        chk("rsp_data", rsp_data, sb[0].data);
        chk("rsp_err", 64'(rsp_err), 64'(sb[0].err));
        chk("resp_no_ready", 64'(req_ready), 0);
        if (!prev_rv && lat_ref != 0)
          chk("rsp_latency", 64'(cyc - (lat_ref == 1 ? gnt_cyc : iss_cyc)), 64'(lat_exp));
        if (rsp_rdy) begin
          void'(sb.pop_front());
          hs_cyc = cyc;
        end
      end
    end
    prev_rv = rsp_valid && !rsp_rdy;
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k = 0;
    while ((sb.size() != 0 || exp_gnt.size() != 0) && k < 200) begin
      tick(1);
      k++;
    end
    chk("drain_done", 64'(sb.size() + exp_gnt.size()), 0);
    tick(2);
  endtask

  task automatic wait_gnt(int target);
    int k = 0;
    while (ngnt < target && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("wait_gnt", 64'(ngnt >= target), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(int g, logic [63:0] x);
    int k = 0;
    xs[g] = x;
    req_valid[g] = 1'b1;
    do begin
      @(negedge clk);
      k++;
    end while (!req_ready[g] && k < 100);
    chk("send_accept", 64'(req_ready[g]), 1);
    @(posedge clk);
    #1;
    req_valid[g] = 1'b0;
  endtask

  task automatic cfg_write(logic [63:0] m, logic [63:0] bl, logic [63:0] minv);
    int k = 0;
    cfg_we = 1'b1;
    cfg_m = m;
    cfg_bl = bl;
    cfg_minv = minv;
    exp_m = m;
    exp_bl = bl;
    exp_minv = minv;
    do begin
      @(negedge clk);
      k++;
    end while (!cfg_ready && k < 100);
    chk("cfg_accept", 64'(cfg_ready), 1);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    cfg_we = 1'b0;
    spur = 1'b0;
    rsp_rdy = 1'b1;
    sb.delete();
    exp_gnt.delete();
    exp_m = '0;
    exp_bl = '0;
    exp_minv = '0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int s0, base;
    for (int i = 0; i < N; i++) xs[i] = '0;
    #12;
    chk("rst_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_cfg_ready", 64'(cfg_ready), 0);
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_red_start", 64'(red_start), 0);
    chk("rst_tcnt", 64'(tcnt), 0);
    chk("rst_red_m", red_m, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1);
    chk("idle_cfg_ready", 64'(cfg_ready), 1);
    // single requester 2, stub x+1
    cfg_write(64'd97, 64'd7, 64'd95);
    mode = 0;
    lat_ref = 1;
    lat_exp = 7;
    s0 = starts;
    exp_gnt.push_back(2);
    send(2, 64'd10);
    drain();
    chk("t1_starts", 64'(starts - s0), 1);
    // all four held valid from pointer 0
    do_reset();
    cfg_write(64'd97, 64'd7, 64'd95);
    for (int i = 0; i < N; i++) xs[i] = 64'(i);
    exp_gnt = '{0, 1, 2, 3, 0};
    base = ngnt;
    req_valid = '1;
    wait_gnt(base + 5);
    req_valid = '0;
    drain();
    // config write in the same cycle as a grant, Montgomery stub
    cfg_write(64'd55, 64'd6, 64'd1);
    mode = 2;
    mont_exp = 64'd44;
    cfg_we = 1'b1;
    cfg_m = 64'd97;
    cfg_bl = 64'd7;
    cfg_minv = 64'd95;
    exp_m = 64'd97;
    exp_bl = 64'd7;
    exp_minv = 64'd95;
    exp_gnt.push_back(0);
    send(0, 64'd200);
    cfg_we = 1'b0;
    drain();
    // watchdog timeout then normal service
    mode = 1;
    lat_ref = 2;
    lat_exp = 16;
    exp_gnt.push_back(1);
    send(1, 64'd5);
    drain();
    chk("t4_tcnt", 64'(tcnt), 1);
    mode = 0;
    lat_ref = 1;
    lat_exp = 7;
    exp_gnt.push_back(3);
    send(3, 64'd33);
    drain();
    // back-pressure on the response with requests pending
    rsp_rdy = 1'b0;
    exp_gnt.push_back(1);
    send(1, 64'd7);
    xs[2] = 64'd8;
    xs[3] = 64'd9;
    req_valid[3:2] = 2'b11;
    exp_gnt.push_back(2);
    exp_gnt.push_back(3);
    for (int k = 0; k < 50 && !rsp_valid; k++) tick(1);
    s0 = starts;
    base = ngnt;
    tick(10);
    chk("t5_starts", 64'(starts - s0), 0);
    chk("t5_grants", 64'(ngnt - base), 0);
    chk("t5_held", 64'(rsp_valid), 1);
    gap_chk = 1;
    rsp_rdy = 1'b1;
    wait_gnt(base + 2);
    req_valid = '0;
    drain();
    // reset during WAIT, then a spurious reducer valid in IDLE
    exp_gnt.push_back(0);
    send(0, 64'd50);
    tick(2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rsp_valid", 64'(rsp_valid), 0);
    chk("t6_red_start", 64'(red_start), 0);
    chk("t6_cfg_ready", 64'(cfg_ready), 0);
    chk("t6_red_x", red_x, 0);
    chk("t6_red_m", red_m, 0);
    chk("t6_tcnt", 64'(tcnt), 0);
    sb.delete();
    exp_gnt.delete();
    exp_m = '0;
    exp_bl = '0;
    exp_minv = '0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    spur = 1'b1;
    tick(1);
    spur = 1'b0;
    tick(8);
    chk("t6_no_rsp", 64'(rsp_valid), 0);
    for (int i = 0; i < N; i++) xs[i] = 64'(100 + i);
    exp_gnt.push_back(0);
    base = ngnt;
    req_valid = '1;
    wait_gnt(base + 1);
    req_valid = '0;
    drain();
    chk("gnt_left", 64'(exp_gnt.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
